// File: rtl/imem_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// Depth is 64 words; the zero word is a MIPS NOP (sll $0,$0,0).
package imem_loader_pkg;

    localparam int          IMEM_ADDR_W = 6;
    localparam int          IMEM_DEPTH  = 64;
    localparam logic [31:0] NOP_WORD    = 32'h0000_0000;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        FILL  = 2'd2,
        DONE  = 2'd3
    } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// Handshake: a byte transfers on a posedge where s_valid and s_ready are both 1;
// the source holds s_valid/s_data/s_last stable until then, and s_ready never depends on s_valid.
interface imem_loader_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
);
    logic              s_valid;
    logic              s_ready;
    logic [7:0]        s_data;
    logic              s_last;
    logic              im_we;
    logic [ADDR_W-1:0] im_wa;
    logic [DATA_W-1:0] im_wd;

    modport master (
        output s_valid, s_data, s_last,
        input  s_ready, im_we, im_wa, im_wd
    );

    modport slave (
        input  s_valid, s_data, s_last,
        output s_ready, im_we, im_wa, im_wd
    );
endinterface

// File: rtl/imem_loader_byte_packer_4x8.sv
// Packs big-endian bytes into 32-bit words; a short final word is left-justified
// with zero padding. word_o/word_valid_o describe the word completed by the current transfer.
module byte_packer_4x8 (
    input  logic        clk,
    input  logic        rst,
    input  logic        accept_i,
    input  logic [7:0]  byte_i,
    input  logic        last_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [23:0] shift_q, shift_d;
    logic [1:0]  cnt_q, cnt_d;

    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        // Older-word bytes sitting above the current ones fall off the top of the shift.
        word_o       = {shift_q, byte_i} << {(2'd3 - cnt_q), 3'b000};
        word_valid_o = accept_i && ((cnt_q == 2'd3) || last_i);
        if (accept_i) begin
            shift_d = {shift_q[15:0], byte_i};
            cnt_d   = word_valid_o ? 2'd0 : cnt_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Fills the instruction memory from a byte stream, zero-fills the tail and
// holds the core in reset until every word has been written.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    imem_loader_if.slave  bus,
    output logic          cpu_rst,
    output logic          done,
    output logic          error,
    output loader_state_e dbg_state_o
);
    localparam int unsigned       DEPTH   = (ADDR_W == IMEM_ADDR_W) ? IMEM_DEPTH : (1 << ADDR_W);
    localparam logic [ADDR_W-1:0] LAST_WA = ADDR_W'(DEPTH - 1);

    loader_state_e     state_q;
    logic [ADDR_W-1:0] word_cnt_q;
    logic [ADDR_W-1:0] im_wa_q;
    logic [DATA_W-1:0] im_wd_q;
    logic              s_ready_q, im_we_q, cpu_rst_q, done_q, error_q, last_q;

    logic              accept;
    logic              word_valid;
    logic [31:0]       word;
    logic [ADDR_W-1:0] wa_next;

    assign accept  = bus.s_valid & s_ready_q;
    assign wa_next = word_cnt_q + ADDR_W'(1);

    byte_packer_4x8 u_packer (
        .clk          (clk),
        .rst          (rst),
        .accept_i     (accept),
        .byte_i       (bus.s_data),
        .last_i       (bus.s_last),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= LOAD;
            word_cnt_q <= '0;
            im_wa_q    <= '0;
            im_wd_q    <= '0;
            s_ready_q  <= 1'b1;
            im_we_q    <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            case (state_q)
                LOAD: begin
                    if (word_valid) begin
                        state_q   <= WRITE;
                        s_ready_q <= 1'b0;
                        im_we_q   <= 1'b1;
                        im_wa_q   <= word_cnt_q;
                        im_wd_q   <= DATA_W'(word);
                        last_q    <= bus.s_last;
                    end
                end
                WRITE: begin
                    word_cnt_q <= wa_next;
                    if (word_cnt_q == LAST_WA) begin
                        state_q <= DONE;
                        im_we_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (last_q) begin
                        state_q <= FILL;
                        im_wa_q <= wa_next;
                        im_wd_q <= DATA_W'(NOP_WORD);
                    end else begin
                        state_q   <= LOAD;
                        im_we_q   <= 1'b0;
                        s_ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (word_cnt_q == LAST_WA) begin
                        state_q <= DONE;
                        im_we_q <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        word_cnt_q <= wa_next;
                        im_wa_q    <= wa_next;
                    end
                end
                DONE: begin
                    // Release one cycle after entry so the core's PC init sees a complete image.
                    cpu_rst_q <= 1'b0;
                    if (!last_q && bus.s_valid) begin
                        error_q <= 1'b1;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.im_we   = im_we_q;
    assign bus.im_wa   = im_wa_q;
    assign bus.im_wd   = im_wd_q;
    assign cpu_rst     = cpu_rst_q;
    assign done        = done_q;
    assign error       = error_q;
    assign dbg_state_o = state_q;
endmodule
